// File: rtl/packet_pkg.sv
// Shared packet constants, header layout and arbiter state type for the switch egress path.
package packet_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_PORTS   = 4;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 4;
    localparam int HDR_DST_MSB = 3;
    localparam int HDR_DST_LSB = 2;
    localparam int HDR_SRC_MSB = 1;
    localparam int HDR_SRC_LSB = 0;
    localparam int PORT_BWIDTH = $clog2(NUM_PORTS);

    typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;

    typedef struct packed {
        logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len;
        logic [HDR_DST_MSB-HDR_DST_LSB:0] dst;
        logic [HDR_SRC_MSB-HDR_SRC_LSB:0] src;
    } pkt_hdr_t;

    function automatic pkt_hdr_t decode_hdr(input logic [HDR_LEN_MSB:HDR_SRC_LSB] raw);
        return pkt_hdr_t'(raw);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any
);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = W'(cand);
            end
        end
    end

endmodule

// File: rtl/egress_port_arbiter.sv
// Per-output-port arbiter: picks one input FIFO whose head header targets PORT_ID and
// drains exactly one whole packet from it onto a valid/ready egress stream.
//
// state    | meaning
// ARB_IDLE | evaluating head headers; grant on any matching, non-busy input
// ARB_XFER | draining LEN+1 words from input g; exits when eop is accepted
module egress_port_arbiter #(
    parameter int PORT_ID    = 0,
    parameter int NUM_PORTS  = packet_pkg::NUM_PORTS,
    parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_PORTS-1:0]                    fifo_empty,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/2-1:0]  header_in,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    fifo_data,
    output logic [NUM_PORTS-1:0]                    fifo_rd_en,
    input  logic [NUM_PORTS-1:0]                    in_busy,
    output logic [NUM_PORTS-1:0]                    in_owned,
    output logic [DATA_WIDTH-1:0]                   out_data,
    output logic                                    out_valid,
    output logic                                    out_sop,
    output logic                                    out_eop,
    input  logic                                    out_ready
);
    import packet_pkg::*;

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [HDR_DST_MSB-HDR_DST_LSB:0] MY_DST = (HDR_DST_MSB-HDR_DST_LSB+1)'(PORT_ID);

    arb_state_t           state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        g;
    logic [4:0]           remaining;
    logic                 rd_pending;
    logic                 first_flag;
    logic                 last_flag;
    logic                 sop_pend;
    logic [NUM_PORTS-1:0] owned;

    pkt_hdr_t             hdr [NUM_PORTS];
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt_onehot;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic                 rd_issue;
    logic                 unused_src;

    always_comb begin
        req        = '0;
        unused_src = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hdr[i]     = decode_hdr(header_in[i][HDR_LEN_MSB:HDR_SRC_LSB]);
            req[i]     = !fifo_empty[i] && (hdr[i].dst == MY_DST) && !in_busy[i];
            unused_src = unused_src ^ (^hdr[i].src);
        end
    end

    rr_arbiter #(.N(NUM_PORTS), .W(PW)) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (gnt_onehot),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    // A new read is only issued once the pending word has been (or is being) accepted,
    // so fifo_data[g] stays frozen under backpressure.
    assign rd_issue = !rst && (state == ARB_XFER) && !fifo_empty[g] && (remaining != 5'd0)
                      && (!rd_pending || out_ready);

    always_comb begin
        fifo_rd_en    = '0;
        fifo_rd_en[g] = rd_issue;
    end

    assign out_data  = fifo_data[g];
    assign out_valid = rd_pending;
    assign out_sop   = rd_pending && first_flag;
    assign out_eop   = rd_pending && last_flag;
    assign in_owned  = owned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            g          <= '0;
            remaining  <= '0;
            rd_pending <= 1'b0;
            first_flag <= 1'b0;
            last_flag  <= 1'b0;
            sop_pend   <= 1'b0;
            owned      <= '0;
        end else begin
            rd_pending <= rd_issue || (rd_pending && !out_ready);
            if (rd_issue) begin
                remaining  <= remaining - 5'd1;
                last_flag  <= (remaining == 5'd1);
                first_flag <= sop_pend;
                sop_pend   <= 1'b0;
            end
            case (state)
                ARB_IDLE: begin
                    if (gnt_any) begin
                        g         <= gnt_idx;
                        remaining <= {1'b0, hdr[gnt_idx].len} + 5'd1;
                        sop_pend  <= 1'b1;
                        rr_ptr    <= (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + PW'(1);
                        owned     <= gnt_onehot;
                        state     <= ARB_XFER;
                    end
                end
                ARB_XFER: begin
                    if (rd_pending && out_ready && last_flag) begin
                        owned <= '0;
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_port_arbiter.sv
// Bench for egress_port_arbiter: FIFO model, packet-level round-robin model and word scoreboard,
// plus directed scenarios with hand-computed cycle expectations.
module tb_egress_port_arbiter;
    import packet_pkg::*;

    localparam int NP  = 4;
    localparam int DW  = 16;
    localparam int PID = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]             fifo_empty = '1;
    logic [NP-1:0][DW/2-1:0]   header_in  = '0;
    logic [NP-1:0][DW-1:0]     fifo_data  = '0;
    logic [NP-1:0]             fifo_rd_en;
    logic [NP-1:0]             in_busy;
    logic [NP-1:0]             in_owned;
    logic [DW-1:0]             out_data;
    logic                      out_valid, out_sop, out_eop, out_ready;

    always #5 clk = ~clk;

    egress_port_arbiter #(.PORT_ID(PID), .NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .header_in  (header_in),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .in_busy    (in_busy),
        .in_owned   (in_owned),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int            port;
    } exp_t;

    logic [DW-1:0] fq [NP][$];
    logic [DW-1:0] mq [NP][$];
    logic [NP-1:0] hold = '0;
    exp_t          exp_q[$];
    int            got_order[$];
    int            acc_cnt = 0;
    int            m_ptr = 0;
    int            errors = 0;
    int            checks = 0;

    // Registered-output FIFO: rd_en pops into fifo_data; empty/head reflect post-pop contents.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (fifo_rd_en[i] && fq[i].size() > 0) fifo_data[i] <= fq[i].pop_front();
            fifo_empty[i] <= (fq[i].size() == 0) || hold[i];
            header_in[i]  <= (fq[i].size() > 0) ? fq[i][0][7:0] : 8'h00;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [DW-1:0] w, input bit to_model);
        fq[p].push_back(w);
        if (to_model) mq[p].push_back(w);
    endtask

    // Packet-level model: repeatedly pick the first eligible head from m_ptr and emit the whole packet.
    task automatic model_arbitrate(input logic [NP-1:0] busy);
        int sel;
        int len;
        exp_t e;
        forever begin
            sel = -1;
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (m_ptr + k) % NP;
                if (sel < 0 && mq[i].size() > 0 && !busy[i] && mq[i][0][3:2] == 2'(PID)) sel = i;
            end
            if (sel < 0) break;
            len = int'(mq[sel][0][7:4]);
            for (int w = 0; w <= len; w++) begin
                e.data = mq[sel].pop_front();
                e.sop  = (w == 0);
                e.eop  = (w == len);
                e.port = sel;
                exp_q.push_back(e);
            end
            m_ptr = (sel + 1) % NP;
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < NP; i++) begin
            fq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        hold    = '0;
        in_busy = '0;
        m_ptr   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("wait_acc", 32'(acc_cnt >= target), 1);
    endtask

    // Per-cycle compare against the scoreboard and protocol invariants.
    initial begin
        logic          pv_stall;
        logic [DW-1:0] pdata;
        logic          psop, peop;
        exp_t          e;
        int            idx;
        pv_stall = 1'b0;
        pdata = '0;
        psop = 1'b0;
        peop = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv_stall = 1'b0;
                continue;
            end
            chk("rd_en_onehot0", 32'($onehot0(fifo_rd_en)), 1);
            chk("owned_onehot0", 32'($onehot0(in_owned)), 1);
            chk("rd_en_not_owned", 32'(fifo_rd_en & ~in_owned), 0);
            chk("rd_en_on_empty", 32'(fifo_rd_en & fifo_empty), 0);
            if (out_valid && !out_ready) chk("rd_en_in_stall", 32'(fifo_rd_en), 0);
            if (pv_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(pdata));
                chk("stall_sop", 32'(out_sop), 32'(psop));
                chk("stall_eop", 32'(out_eop), 32'(peop));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(e.data));
                    chk("word_sop", 32'(out_sop), 32'(e.sop));
                    chk("word_eop", 32'(out_eop), 32'(e.eop));
                    chk("word_owner", 32'(in_owned), 32'(1) << e.port);
                end
                if (out_sop) begin
                    idx = -1;
                    for (int k = 0; k < NP; k++) if (in_owned[k]) idx = k;
                    got_order.push_back(idx);
                end
                acc_cnt++;
            end
            pv_stall = out_valid && !out_ready;
            pdata = out_data;
            psop = out_sop;
            peop = out_eop;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] t_rd  [6] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        logic [3:0] t_own [6] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
        logic       t_v   [6] = '{0, 0, 1, 1, 1, 0};
        logic       t_sop [6] = '{0, 0, 1, 0, 0, 0};
        logic       t_eop [6] = '{0, 0, 0, 0, 1, 0};
        int         exp_ord [4] = '{0, 3, 0, 3};

        rst       = 1'b1;
        out_ready = 1'b1;
        in_busy   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sop", 32'(out_sop), 0);
        chk("rst_eop", 32'(out_eop), 0);
        chk("rst_owned", 32'(in_owned), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single LEN=2 packet on in1: cycle-exact latency
        @(negedge clk);
        acc_cnt = 0;
        push(1, 16'h5A28, 1);
        push(1, 16'h1111, 1);
        push(1, 16'h2222, 1);
        model_arbitrate(in_busy);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t1_rd_en_c%0d", c), 32'(fifo_rd_en), 32'(t_rd[c]));
            chk($sformatf("t1_owned_c%0d", c), 32'(in_owned), 32'(t_own[c]));
            chk($sformatf("t1_valid_c%0d", c), 32'(out_valid), 32'(t_v[c]));
            chk($sformatf("t1_sop_c%0d", c), 32'(out_sop), 32'(t_sop[c]));
            chk($sformatf("t1_eop_c%0d", c), 32'(out_eop), 32'(t_eop[c]));
        end
        chk("t1_state_idle", 32'(dut.state), 32'(ARB_IDLE));
        wait_drain("t1_drain");
        chk("t1_words", acc_cnt, 3);

        // Round robin between in0 and in3, two LEN=0 packets each
        do_reset();
        @(negedge clk);
        got_order.delete();
        push(0, 16'hA008, 1);
        push(0, 16'hB008, 1);
        push(3, 16'hA00B, 1);
        push(3, 16'hB00B, 1);
        model_arbitrate(in_busy);
        wait_drain("rr_drain");
        chk("rr_count", got_order.size(), 4);
        if (got_order.size() == 4)
            for (int k = 0; k < 4; k++) chk($sformatf("rr_order_%0d", k), got_order[k], exp_ord[k]);
        chk("rr_ptr_end", 32'(dut.rr_ptr), 0);

        // Backpressure: LEN=4 on in3, ready low 3 cycles after second word
        acc_cnt = 0;
        push(3, 16'h7C4B, 1);
        for (int w = 1; w <= 4; w++) push(3, 16'h3000 + 16'(w), 1);
        model_arbitrate(in_busy);
        wait_acc(2);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_valid_held", 32'(out_valid), 1);
            chk("bp_no_rd", 32'(fifo_rd_en), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_words", acc_cnt, 5);

        // Underflow: in0 FIFO reads empty for 4 cycles mid-payload
        acc_cnt = 0;
        push(0, 16'h9958, 1);
        for (int w = 1; w <= 5; w++) push(0, 16'h4000 + 16'(w), 1);
        model_arbitrate(in_busy);
        wait_acc(2);
        @(negedge clk);
        hold[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("uf_no_rd", 32'(fifo_rd_en[0]), 0);
            if (c > 0) chk("uf_no_valid", 32'(out_valid), 0);
        end
        hold[0] = 1'b0;
        wait_drain("uf_drain");
        chk("uf_words", acc_cnt, 6);

        // Masking: in2 busy blocks its header; busy in0 with a DST-matching payload at head
        acc_cnt = 0;
        in_busy = 4'b0101;
        push(0, 16'h0008, 0);
        push(2, 16'h1E0A, 1);
        model_arbitrate(in_busy);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk("mask_owned", 32'(in_owned), 0);
            chk("mask_rd_en", 32'(fifo_rd_en), 0);
            chk("mask_valid", 32'(out_valid), 0);
        end
        @(negedge clk);
        in_busy = 4'b0001;
        model_arbitrate(in_busy);
        @(negedge clk);
        #1;
        chk("mask_grant_next", 32'(in_owned), 32'h4);
        wait_drain("mask_drain");
        chk("mask_words", acc_cnt, 1);

        // Reset in the middle of a LEN=4 packet on in1
        acc_cnt = 0;
        push(1, 16'h6649, 1);
        for (int w = 1; w <= 4; w++) push(1, 16'h5000 + 16'(w), 1);
        model_arbitrate(in_busy);
        wait_acc(1);
        chk("mr_in_xfer", 32'(dut.state), 32'(ARB_XFER));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_owned", 32'(in_owned), 0);
        chk("mr_rd_en", 32'(fifo_rd_en), 0);
        chk("mr_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("mr_rr_ptr", 32'(dut.rr_ptr), 0);
        flush_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/egress_port_arbiter.md
Name: egress_port_arbiter

Overview:
- One instance per switch output port, sitting directly downstream of the NUM_PORTS input FIFOs.
- It inspects each FIFO's head header and round-robin arbitrates among inputs whose destination field matches PORT_ID.
- It then drains exactly one whole packet (header plus payload) from the winning FIFO into a valid/ready egress stream.
- The top level ORs fifo_rd_en across arbiters per input, and feeds in_busy from the other arbiters' in_owned.

Parameters:
- PORT_ID, 0: output port number this instance serves (0..NUM_PORTS-1).
- NUM_PORTS, 4 (packet_pkg): number of input FIFOs.
- DATA_WIDTH, 16 (packet_pkg): FIFO word width. Must be ≥16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- fifo_empty  in  NUM_PORTS  per-input FIFO empty
- header_in  in  NUM_PORTS x DATA_WIDTH/2  per-input FIFO head-word inspection value
- fifo_data  in  NUM_PORTS x DATA_WIDTH  per-input FIFO data_out (registered; valid 1 cycle after rd_en)
- fifo_rd_en  out  NUM_PORTS  per-input read strobe (one-hot or zero)
- in_busy  in  NUM_PORTS  input currently owned by another arbiter
- in_owned  out  NUM_PORTS  input owned by this arbiter (one-hot or zero)
- out_data  out  DATA_WIDTH  egress word
- out_valid  out  1  egress word valid
- out_sop  out  1  egress word is packet header
- out_eop  out  1  egress word is last word of packet
- out_ready  in  1  downstream accepts word

Behaviour:
- Header format, bits [7:0] of header word:
  - [7:4] LEN: payload words, 0..15; the packet is LEN+1 words.
  - [3:2] DST.
  - [1:0] SRC.
- Request: req[i] = !fifo_empty[i] && header_in[i][3:2]==PORT_ID && !in_busy[i]. Evaluated only in IDLE.
- FSM: IDLE, XFER.
  - IDLE with any req: grant g = first requesting input starting from rr_ptr, wrapping modulo NUM_PORTS. Register g. Load remaining = LEN+1. Set sop_pend=1. rr_ptr <= (g+1) mod NUM_PORTS. Go to XFER.
  - IDLE with no req: stay in IDLE; rr_ptr unchanged.
- XFER read issue (combinational): rd_issue = !fifo_empty[g] && remaining!=0 && (!rd_pending || out_ready). fifo_rd_en[g] = rd_issue. All other bits are 0.
- rd_pending <= rd_issue || (rd_pending && !out_ready).
- remaining decrements on each rd_issue.
- last_flag and first_flag are registered with each rd_issue:
  - last_flag = (remaining==1).
  - first_flag = sop_pend; sop_pend clears on the first issue.
- Egress outputs:
  - out_valid = rd_pending.
  - out_data = fifo_data[g] (combinational mux). It stays stable under stall because no new rd_en is issued.
  - out_sop = rd_pending && first_flag.
  - out_eop = rd_pending && last_flag.
- XFER -> IDLE on the cycle out_valid && out_ready && out_eop. At least one IDLE cycle separates packets.
- in_owned[g] = 1 throughout XFER, 0 in IDLE.
- Latency: header visible and requesting at cycle t → fifo_rd_en at t+1 → out_valid/out_sop at t+2. Full throughput of one word per cycle while out_ready=1 and the FIFO is non-empty.
- FIFO empties mid-packet: hold XFER and issue no reads. Resume when non-empty. No timeout.
- out_ready low: no new read while a word is pending; out_* held stable.
- LEN=0: a single word with out_sop=out_eop=1.
- header_in is ignored during XFER; payload bits never cause grants.
- Reset:
  - Registers: state=IDLE, rr_ptr=0, g=0, remaining=0, rd_pending=0, flags=0.
  - Outputs: out_valid=0, out_sop=0, out_eop=0, in_owned=0, fifo_rd_en=0 (forced 0 while rst=1).
  - Reset mid-packet abandons the packet; the FIFO is reset alongside.

Decomposition:
- packet_pkg constants:
  - DATA_WIDTH, NUM_PORTS, HDR_LEN_MSB/LSB=7/4, HDR_DST_MSB/LSB=3/2, HDR_SRC_MSB/LSB=1/0.
  - PORT_BWIDTH=$clog2(NUM_PORTS).
  - typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t.
  - typedef struct packed {len, dst, src} pkt_hdr_t.
- Sub-module rr_arbiter (req vector, pointer → one-hot grant and index); purely combinational, reusable.

Test Plan:
- Single packet: in1 head 0x28 (LEN=2, DST=2) to PORT_ID=2, out_ready=1.
  - fifo_rd_en[1] pulses 3 consecutive cycles starting t+1.
  - out_valid t+2..t+4; out_sop at t+2, out_eop at t+4; data in order; state returns to IDLE at t+5.
- Round robin: in0 and in3 each hold two LEN=0 packets to this port.
  - Grant order 0,3,0,3; rr_ptr ends at 0.
- Backpressure: LEN=4 packet with out_ready=0 for 3 cycles after the second word.
  - out_data and out_valid stable; no fifo_rd_en during stall; all 5 words delivered once, in order.
- Underflow stall: fifo_empty[g]=1 for 4 cycles mid-payload.
  - No rd_en and no out_valid during the gap; eop still on word LEN+1.
- Masking: req on in2 with in_busy[2]=1 → no grant. Deassert in_busy → grant on the next IDLE cycle.
  - A payload word with DST==PORT_ID on another input causes no grant while that input is in_busy.
- Reset mid-packet: assert rst during XFER.
  - Next cycle out_valid=0, in_owned=0, fifo_rd_en=0, state=IDLE, rr_ptr=0.
